// File: rtl/control_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// control_unit: multi-cycle fetch/execute sequencer driving datapath strobes.
// Revision: 1.0
// ----------------------------------------------------------------------------
module control_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] opcode,
  input  logic       mem_rdy,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       Cout,
  output logic       PCout,
  output logic       PCin,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Yin,
  output logic       Zin,
  output logic       Zlowout,
  output logic       Read,
  output logic       Write,
  output logic [4:0] alu_op,
  output logic       run
);

  // T1 is split into a first cycle (strobes PCin) and a wait cycle (no PCin),
  // so that every output stays a pure function of state and opcode.
  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T1W  = 4'd3;
  localparam logic [3:0] S_T2   = 4'd4;
  localparam logic [3:0] S_T3   = 4'd5;
  localparam logic [3:0] S_T4   = 4'd6;
  localparam logic [3:0] S_T5   = 4'd7;
  localparam logic [3:0] S_T6   = 4'd8;
  localparam logic [3:0] S_T7   = 4'd9;
  localparam logic [3:0] S_HALT = 4'd10;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       is_r;
  logic       is_imm;
  logic       is_ldi;
  logic       is_ld;
  logic       is_st;
  logic       is_halt;
  logic [4:0] imm_alu;

  assign is_r    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign is_ldi  = (opcode == OP_LDI);
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_halt = (opcode == OP_HALT);

  always_comb begin
    case (opcode)
      OP_ANDI: imm_alu = OP_AND;
      OP_ORI:  imm_alu = OP_OR;
      default: imm_alu = OP_ADD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_RST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_RST;
    case (state)
      S_RST:  state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1,
      S_T1W:  state_nxt = mem_rdy ? S_T2 : S_T1W;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        if (is_halt)                                    state_nxt = S_HALT;
        else if (is_r || is_imm || is_ldi || is_ld || is_st) state_nxt = S_T4;
        else                                            state_nxt = S_T0;
      end
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = (is_ld || is_st) ? S_T6 : S_T0;
      S_T6: begin
        if (is_ld)      state_nxt = mem_rdy ? S_T7 : S_T6;
        else if (is_st) state_nxt = S_T7;
        else            state_nxt = S_T0;
      end
      S_T7: begin
        if (is_st) state_nxt = mem_rdy ? S_T0 : S_T7;
        else       state_nxt = S_T0;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; Zlowout = 1'b0; Read = 1'b0; Write = 1'b0;
    alu_op = 5'b00000;
    run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T1W: begin
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        if (is_r || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end
      end
      S_T4: begin
        if (is_r) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu;
        end else if (is_ldi || is_ld || is_st) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
        end
      end
      S_T5: begin
        if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_r || is_imm || is_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
